// File: rtl/snax_hwpe_periph_arb_pkg.sv
// Shared types and constants for the HWPE peripheral-port arbiter.
// Holds the arbiter state encoding, the registered request payload and
// the data word returned to a requester when a read response never arrives.
package snax_hwpe_periph_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  // Widest transaction id the payload can carry; IdWidth must not exceed it.
  localparam int unsigned MaxIdWidth = 32;

  typedef struct packed {
    logic [MaxIdWidth-1:0] id;
    logic [31:0]           add;
    logic                  wen;
    logic [3:0]            be;
    logic [31:0]           data;
  } payload_t;

  localparam logic [31:0] TimeoutData = 32'hDEAD_BEEF;

  // Index width for a vector of n entries, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snax_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports: clk_i/rst_ni, req (request vector), adv (commit the current winner),
//        gnt (one-hot winner, zero if no request), idx (winner index), found.
// The search starts one past the last winner; the pointer resets to NumReq-1
// so requester 0 has first priority after reset.
module snax_rr_arbiter
  import snax_hwpe_periph_arb_pkg::*;
#(
  parameter int unsigned NumReq = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumReq-1:0]                 req,
  input  logic                              adv,
  output logic [NumReq-1:0]                 gnt,
  output logic [idx_width(NumReq)-1:0]      idx,
  output logic                              found
);

  localparam int unsigned IdxW = idx_width(NumReq);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW:0]   cand_sum;
  logic [IdxW-1:0] cand;

  // Walk offsets 1..NumReq from the pointer; the first hit wins, so the
  // last winner is considered only when nobody else is requesting.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand_sum = {1'b0, ptr_q} + (IdxW+1)'(k);
      if (cand_sum >= (IdxW+1)'(NumReq)) begin
        cand_sum = cand_sum - (IdxW+1)'(NumReq);
      end
      cand = cand_sum[IdxW-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= IdxW'(NumReq - 1);
    end else if (adv && found) begin
      ptr_q <= idx;
    end
  end

endmodule

// File: rtl/snax_hwpe_periph_arbiter.sv
// Shares one HWPE 32-bit peripheral port between NumReq requesters with
// round-robin arbitration and a single outstanding transaction; the shared
// port is driven from registers and read responses are routed to the issuer.
// Ports: clk_i/rst_ni; in_* per-requester request side (req/gnt/add/wen/be/
//        data/id, r_valid one-hot, shared r_data/r_id); out_* shared port
//        (req/gnt/add/wen/be/data/id, r_valid/r_data/r_id); timeout_o pulse.
// Optional: define SNAX_HWPE_PERIPH_ARB_TIMEOUT_EN to add a read-response
// watchdog that answers with 32'hDEAD_BEEF after TimeoutCycles WAIT_RSP cycles.
module snax_hwpe_periph_arbiter
  import snax_hwpe_periph_arb_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned IdWidth       = 5,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumReq-1:0]         in_req_i,
  output logic [NumReq-1:0]         in_gnt_o,
  input  logic [NumReq*32-1:0]      in_add_i,
  input  logic [NumReq-1:0]         in_wen_i,
  input  logic [NumReq*4-1:0]       in_be_i,
  input  logic [NumReq*32-1:0]      in_data_i,
  input  logic [NumReq*IdWidth-1:0] in_id_i,
  output logic [NumReq-1:0]         in_r_valid_o,
  output logic [31:0]               in_r_data_o,
  output logic [IdWidth-1:0]        in_r_id_o,
  output logic                      out_req_o,
  input  logic                      out_gnt_i,
  output logic [31:0]               out_add_o,
  output logic                      out_wen_o,
  output logic [3:0]                out_be_o,
  output logic [31:0]               out_data_o,
  output logic [IdWidth-1:0]        out_id_o,
  input  logic                      out_r_valid_i,
  input  logic [31:0]               out_r_data_i,
  input  logic [IdWidth-1:0]        out_r_id_i,
  output logic                      timeout_o
);

  localparam int unsigned IdxW = idx_width(NumReq);

  state_e              state_q;
  payload_t            pl_q;
  payload_t            win_pl;
  logic                out_req_q;
  logic [IdxW-1:0]     owner_q;
  logic [NumReq-1:0]   rsp_vld_q;
  logic [31:0]         rsp_data_q;
  logic [IdWidth-1:0]  rsp_id_q;

  logic [NumReq-1:0]   arb_gnt;
  logic [IdxW-1:0]     arb_idx;
  logic                arb_found;
  logic                arb_adv;

`ifdef SNAX_HWPE_PERIPH_ARB_TIMEOUT_EN
  localparam int unsigned CntW = idx_width(TimeoutCycles);
  logic [CntW-1:0]     cnt_q;
  logic [IdWidth-1:0]  req_id_q;   // survives the payload clear on out_gnt_i
  logic                timeout_q;
`endif

  // The pointer only moves when a grant is actually handed out in IDLE.
  assign arb_adv = (state_q == IDLE);

  snax_rr_arbiter #(
    .NumReq (NumReq)
  ) i_rr_arbiter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (in_req_i),
    .adv    (arb_adv),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .found  (arb_found)
  );

  assign in_gnt_o = (state_q == IDLE) ? arb_gnt : '0;

  // Payload of the winning requester; the grant is one-hot so at most one
  // branch fires.
  always_comb begin
    win_pl = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (arb_gnt[i]) begin
        win_pl.id   = MaxIdWidth'(in_id_i[i*IdWidth +: IdWidth]);
        win_pl.add  = in_add_i[i*32 +: 32];
        win_pl.wen  = in_wen_i[i];
        win_pl.be   = in_be_i[i*4 +: 4];
        win_pl.data = in_data_i[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pl_q       <= '0;
      out_req_q  <= 1'b0;
      owner_q    <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
`ifdef SNAX_HWPE_PERIPH_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      req_id_q   <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      // Response outputs are single-cycle and read as zero when idle.
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
`ifdef SNAX_HWPE_PERIPH_ARB_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (arb_found) begin
            pl_q      <= win_pl;
            out_req_q <= 1'b1;
            owner_q   <= arb_idx;
            state_q   <= ISSUE;
`ifdef SNAX_HWPE_PERIPH_ARB_TIMEOUT_EN
            req_id_q  <= IdWidth'(win_pl.id);
`endif
          end
        end
        ISSUE: begin
          if (out_gnt_i) begin
            out_req_q <= 1'b0;
            pl_q      <= '0;
            if (pl_q.wen) begin
              state_q <= WAIT_RSP;
`ifdef SNAX_HWPE_PERIPH_ARB_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end else begin
              state_q <= IDLE;
            end
          end
        end
        WAIT_RSP: begin
          // A real response takes precedence over an expiring watchdog.
          if (out_r_valid_i) begin
            rsp_vld_q  <= NumReq'(1) << owner_q;
            rsp_data_q <= out_r_data_i;
            rsp_id_q   <= out_r_id_i;
            state_q    <= IDLE;
          end
`ifdef SNAX_HWPE_PERIPH_ARB_TIMEOUT_EN
          else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
            rsp_vld_q  <= NumReq'(1) << owner_q;
            rsp_data_q <= TimeoutData;
            rsp_id_q   <= req_id_q;
            timeout_q  <= 1'b1;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_req_o    = out_req_q;
  assign out_add_o    = pl_q.add;
  assign out_wen_o    = pl_q.wen;
  assign out_be_o     = pl_q.be;
  assign out_data_o   = pl_q.data;
  assign out_id_o     = IdWidth'(pl_q.id);
  assign in_r_valid_o = rsp_vld_q;
  assign in_r_data_o  = rsp_data_q;
  assign in_r_id_o    = rsp_id_q;

`ifdef SNAX_HWPE_PERIPH_ARB_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
